regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write-port register file in the core datapath.
- Provides NREAD asynchronous read ports and two general write ports (A, B).
- Includes a dedicated program-counter register at the top index (DEPTH-1) with its own write port and reset value.
- Includes a hardware clear sequencer that zeroes the general registers one entry per cycle after reset or on request. The decode/execute stage uses `busy` to stall until the clear completes.

Parameters:
- WIDTH, 32, data width of every register.
- DEPTH, 16, number of architectural registers; index DEPTH-1 is the PC; must be a power of two, ≥4.
- NREAD, 3, number of read ports.
- PC_RESET, 0, value loaded into the PC on reset.
- (local) AW = clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rA  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rD  out  NREAD*WIDTH  packed read data; port i uses bits [i*WIDTH +: WIDTH].
- wEnA  in  1  write enable, port A.
- wAA  in  AW  write address, port A.
- wDA  in  WIDTH  write data, port A.
- wEnB  in  1  write enable, port B.
- wAB  in  AW  write address, port B.
- wDB  in  WIDTH  write data, port B.
- wEnPc  in  1  PC write enable.
- wDPc  in  WIDTH  PC write data.
- rDPc  out  WIDTH  current PC value.
- clr_req  in  1  request a clear of the general registers.
- busy  out  1  clear sequence in progress.

Behaviour:
- Storage:
  - Entries 0..DEPTH-2 are a memory array with no async reset.
  - The PC is a separate flop with async reset to PC_RESET.
- Reset (asserted at any time, including mid-clear):
  - PC = PC_RESET.
  - FSM enters CLEAR with cnt = 0 and busy = 1.
  - All rD = 0; rDPc = PC_RESET.
- FSM states:
  - IDLE:
    - busy = 0.
    - clr_req = 1 → CLEAR, cnt = 0, on the next edge.
  - CLEAR:
    - busy = 1.
    - Each cycle writes entry cnt = 0 and increments cnt.
    - When cnt == DEPTH-2 is written → IDLE.
    - Duration is exactly DEPTH-1 cycles.
    - clr_req during CLEAR is ignored; the sequence does not restart.
- While busy:
  - wEnA and wEnB are ignored.
  - All rD outputs read as 0.
  - wEnPc and rDPc operate normally; the PC is never cleared by the sequencer.
- Reads (combinational):
  - rD[i] = entry rA[i].
  - rA[i] == DEPTH-1 returns the PC.
  - Without the bypass option, reads return pre-edge contents (read-old).
- Writes on the rising edge, when not busy:
  - wEnA writes wDA to wAA; wEnB writes wDB to wAB.
  - Same-address conflict between A and B: port B wins.
  - A or B targeting DEPTH-1 writes the PC, unless wEnPc is asserted in the same cycle (wEnPc has highest priority).
  - wEnPc = 0 with no A/B hit on DEPTH-1: PC holds. This differs from the old block, which loaded PC every cycle.
- Widths: no arithmetic; addresses ≥ DEPTH are not possible because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding.
  - When not busy, a read whose address matches an enabled same-cycle write returns that write data, using the same priority as the write: PC port > B > A.
  - rDPc likewise forwards: wEnPc, else a B write to DEPTH-1, else an A write to DEPTH-1.
- Undefined: reads and rDPc show stored values only. New data is visible the cycle after the edge.

Test Plan:
- Reset and clear: assert rst, release → busy high for exactly 15 cycles (DEPTH=16), then low. All rD = 0 throughout, rDPc = 0. After busy falls, every entry 0..14 reads 0.
- Write/read: write A r3=0x12345678 and B r7=0xDEADBEEF in one cycle → next cycle rD0 (rA=3) = 0x12345678, rD1 (rA=7) = 0xDEADBEEF, rD2 (rA=0) = 0.
- Conflict: A and B both write r5, A=0x1111 and B=0x2222 → r5 reads 0x2222. A writes r15=0x40 with wEnPc=1 and wDPc=0x80 → rDPc = 0x80.
- PC hold: wEnPc=1 with wDPc=0x100, then wEnPc=0 for 5 cycles → rDPc stays 0x100. rA=15 on any read port returns 0x100.
- Mid-operation clear: load r1=0xAA, pulse clr_req, write B r2=0xBB during busy → after 15 cycles r1 = 0 and r2 = 0 (write ignored). rst asserted at clear cycle 7 restarts the count: busy lasts 15 more cycles.
- Bypass (REGFILE_BYPASS_EN): A writes r4=0x55 with rA0=4 in the same cycle → rD0 = 0x55 before the edge. Without the macro → old value 0 until after the edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD async read ports, two write ports, a dedicated PC register
// and a clear sequencer. Define REGFILE_BYPASS_EN for write-first forwarding on reads.
module regfile_mp #(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       NREAD    = 3,
    parameter logic [WIDTH-1:0]  PC_RESET = '0,
    localparam int unsigned      AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rA,
    output logic [NREAD*WIDTH-1:0] rD,
    input  logic                   wEnA,
    input  logic [AW-1:0]          wAA,
    input  logic [WIDTH-1:0]       wDA,
    input  logic                   wEnB,
    input  logic [AW-1:0]          wAB,
    input  logic [WIDTH-1:0]       wDB,
    input  logic                   wEnPc,
    input  logic [WIDTH-1:0]       wDPc,
    output logic [WIDTH-1:0]       rDPc,
    input  logic                   clr_req,
    output logic                   busy
);

    localparam logic [AW-1:0] PcAddr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LastGp = AW'(DEPTH - 2);

    typedef enum logic {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  pc_q, pc_d, pc_rd;
    logic [WIDTH-1:0]  mem_q [DEPTH-1];
    logic              wr_a, wr_b;
    logic [AW-1:0]     rd_addr [NREAD];
    logic [WIDTH-1:0]  rd_val [NREAD];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastGp) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign busy = (state_q == StClear);
    assign wr_a = wEnA && !busy;
    assign wr_b = wEnB && !busy;

    // PC write priority: dedicated port, then B, then A.
    always_comb begin
        pc_d = pc_q;
        if (wr_a && wAA == PcAddr) pc_d = wDA;
        if (wr_b && wAB == PcAddr) pc_d = wDB;
        if (wEnPc)                 pc_d = wDPc;
    end

    // B is assigned last so it wins a same-address conflict with A.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr_a && wAA != PcAddr) mem_q[wAA] <= wDA;
            if (wr_b && wAB != PcAddr) mem_q[wAB] <= wDB;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign pc_rd = rst ? PC_RESET : pc_d;
`else
    assign pc_rd = pc_q;
`endif

    always_comb begin
        rD = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            rd_addr[i] = rA[i*AW +: AW];
            rd_val[i]  = '0;
            if (!busy) begin
                if (rd_addr[i] == PcAddr) begin
                    rd_val[i] = pc_rd;
                end else begin
                    rd_val[i] = mem_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                    if (wr_a && wAA == rd_addr[i]) rd_val[i] = wDA;
                    if (wr_b && wAB == rd_addr[i]) rd_val[i] = wDB;
`endif
                end
            end
            rD[i*WIDTH +: WIDTH] = rd_val[i];
        end
    end

    assign rDPc = pc_rd;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int N  = 3;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] rA;
    logic [N*W-1:0]  rD;
    logic            wEnA, wEnB, wEnPc, clr_req, busy;
    logic [AW-1:0]   wAA, wAB;
    logic [W-1:0]    wDA, wDB, wDPc, rDPc;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(N), .PC_RESET('0)) dut (
        .clk(clk), .rst(rst), .rA(rA), .rD(rD),
        .wEnA(wEnA), .wAA(wAA), .wDA(wDA),
        .wEnB(wEnB), .wAB(wAB), .wDB(wDB),
        .wEnPc(wEnPc), .wDPc(wDPc), .rDPc(rDPc),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] rd;
        logic [W-1:0]   pc;
        logic           busy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    // Reference state: entry 15 is the PC; clear_left counts remaining clear cycles.
    logic [W-1:0] regs [D];
    int          clear_left;
    int          clr_idx;

    function automatic void model_reset();
        regs[D-1]  = '0;
        clear_left = D - 1;
        clr_idx    = 0;
    endfunction

    function automatic exp_t predict();
        exp_t         e;
        logic [W-1:0] view [D];
        logic         b;
        b = (clear_left > 0);
        for (int k = 0; k < D; k++) view[k] = regs[k];
`ifdef REGFILE_BYPASS_EN
        if (!b) begin
            if (wEnA) view[wAA] = wDA;
            if (wEnB) view[wAB] = wDB;
        end
        if (wEnPc && !rst) view[D-1] = wDPc;
`endif
        e.busy = b;
        e.pc   = view[D-1];
        e.rd   = '0;
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = rA[i*AW +: AW];
            e.rd[i*W +: W] = b ? '0 : view[a];
        end
        return e;
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (clear_left > 0) begin
            regs[clr_idx] = '0;
            clr_idx++;
            clear_left--;
        end else begin
            if (wEnA) regs[wAA] = wDA;
            if (wEnB) regs[wAB] = wDB;
            if (clr_req) begin
                clear_left = D - 1;
                clr_idx    = 0;
            end
        end
        if (wEnPc) regs[D-1] = wDPc;
    endfunction

    task automatic cycle();
        if (rst) model_reset();
        q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        wEnA = 0; wEnB = 0; wEnPc = 0; clr_req = 0;
        wAA = '0; wAB = '0; wDA = '0; wDB = '0; wDPc = '0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rA = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Monitor: compares the DUT against the oldest pending expectation mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (rD !== e.rd) begin
                errors++;
                $display("FAIL rD: got %h expected %h (rA=%h)", rD, e.rd, rA);
            end
            checks++;
            if (rDPc !== e.pc) begin
                errors++;
                $display("FAIL rDPc: got %h expected %h", rDPc, e.pc);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy: got %b expected %b", busy, e.busy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < D; k++) regs[k] = '0;
        rst = 1'b1;
        idle_in();
        set_rd(0, 1, 2);
        model_reset();
        @(posedge clk);
        #1;
        // Reset, then the power-on clear and a sweep of every entry.
        repeat (3) cycle();
        rst = 1'b0;
        for (int c = 0; c < 17; c++) begin
            set_rd(c % 16, 15, (c * 5) % 16);
            cycle();
        end
        for (int a = 0; a < 15; a += 3) begin
            set_rd(a, a + 1, a + 2);
            cycle();
        end
        // Dual write, then read back.
        wEnA = 1; wAA = 3; wDA = 32'h1234_5678;
        wEnB = 1; wAB = 7; wDB = 32'hDEAD_BEEF;
        set_rd(3, 7, 0);
        cycle();
        idle_in();
        cycle();
        // Same-address conflict, and PC port beating A on index 15.
        wEnA = 1; wAA = 5; wDA = 32'h1111;
        wEnB = 1; wAB = 5; wDB = 32'h2222;
        set_rd(5, 15, 3);
        cycle();
        idle_in();
        cycle();
        wEnA = 1; wAA = 15; wDA = 32'h40;
        wEnPc = 1; wDPc = 32'h80;
        cycle();
        idle_in();
        cycle();
        // PC hold.
        wEnPc = 1; wDPc = 32'h100;
        cycle();
        idle_in();
        set_rd(15, 15, 15);
        repeat (5) cycle();
        // Mid-operation clear with a write attempted while busy.
        wEnA = 1; wAA = 1; wDA = 32'hAA;
        cycle();
        idle_in();
        clr_req = 1;
        cycle();
        clr_req = 0;
        wEnB = 1; wAB = 2; wDB = 32'hBB;
        set_rd(1, 2, 15);
        cycle();
        idle_in();
        repeat (16) cycle();
        // Reset asserted partway through a clear restarts the count.
        clr_req = 1;
        cycle();
        clr_req = 0;
        repeat (7) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (17) cycle();
        // Same-cycle write and read of one address.
        wEnA = 1; wAA = 4; wDA = 32'h55;
        set_rd(4, 0, 15);
        cycle();
        idle_in();
        cycle();
        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rA      = N*AW'($urandom);
            wEnA    = 1'($urandom_range(0, 1));
            wAA     = AW'($urandom);
            wDA     = $urandom;
            wEnB    = 1'($urandom_range(0, 1));
            wAB     = ($urandom_range(0, 3) == 0) ? wAA : AW'($urandom);
            wDB     = $urandom;
            wEnPc   = ($urandom_range(0, 3) == 0);
            wDPc    = $urandom;
            clr_req = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle_in();
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
